// File: rtl/harvard_bus_adapter_pkg.sv
// ============================================================================
//  Module   : mips_bus_pkg
//  Brief    : Shared types and constants for the Harvard-to-single-bus adapter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_DATA   = 3'd3,
        S_COMMIT = 3'd4,
        S_HALT   = 3'd5
    } adapter_state_t;

    localparam logic [3:0] BYTEEN_FULL = 4'hF;
    localparam logic [3:0] BYTEEN_NONE = 4'h0;

    // Byte offset is left to the core, so the bus always sees a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/harvard_bus_adapter_if.sv
// ============================================================================
//  Module   : harvard_bus_adapter_if
//  Brief    : CPU-side and memory-bus-side signals of the bus adapter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface harvard_bus_adapter_if;

    logic        cpu_active;
    logic        cpu_clk_enable;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest;
    logic [31:0] bus_readdata;
    logic        bus_error;

    // Adapter view: serves the core and masters the memory bus.
    modport master (
        input  cpu_active, instr_address, data_address, data_read, data_write,
               data_writedata, bus_waitrequest, bus_readdata,
        output cpu_clk_enable, instr_readdata, data_readdata, bus_address,
               bus_read, bus_write, bus_writedata, bus_byteenable, bus_error
    );

    // Environment view: the core plus the memory slave.
    modport slave (
        output cpu_active, instr_address, data_address, data_read, data_write,
               data_writedata, bus_waitrequest, bus_readdata,
        input  cpu_clk_enable, instr_readdata, data_readdata, bus_address,
               bus_read, bus_write, bus_writedata, bus_byteenable, bus_error
    );

endinterface

`default_nettype wire

// File: rtl/harvard_bus_adapter_timeout.sv
// ============================================================================
//  Module   : bus_timeout_counter
//  Brief    : Counts consecutive wait cycles of one access; flags the cycle
//             whose increment reaches TIMEOUT_CYCLES.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expired
);

    localparam logic [15:0] c_last = 16'(TIMEOUT_CYCLES - 32'd1);

    logic [15:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 16'd1;
        end
    end

    // Expiry is flagged in the cycle whose increment reaches the limit so the
    // FSM can drop the strobes on that same edge.
    assign o_expired = i_enable && !i_clear && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/harvard_bus_adapter.sv
// ============================================================================
//  Module   : harvard_bus_adapter
//  Brief    : Serialises a Harvard core's fetch and data ports onto one
//             Avalon-style bus and steps the core one instruction at a time.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module harvard_bus_adapter
    import mips_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic            clk,
    input  wire logic            reset,
    harvard_bus_adapter_if.master bus
);

    adapter_state_t r_state;
    adapter_state_t w_state_nxt;
    logic [31:0]    r_instr_q;
    logic [31:0]    r_data_q;
    logic           r_bus_error;
    logic           w_in_access;
    logic           w_accept;
    logic           w_expired;
    logic           w_err_set;

    assign w_in_access = (r_state == S_FETCH) || (r_state == S_DATA);
    assign w_accept    = w_in_access && !bus.bus_waitrequest;

    // Held clear outside the two bus states, so every access starts from zero.
    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (!w_in_access),
        .i_enable  (w_in_access && bus.bus_waitrequest),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_active) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_expired) begin
                    w_state_nxt = S_HALT;
                    w_err_set   = 1'b1;
                end else if (!bus.bus_waitrequest) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (bus.data_read && bus.data_write) begin
                    w_state_nxt = S_HALT;
                    w_err_set   = 1'b1;
                end else if (bus.data_read || bus.data_write) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_DATA: begin
                if (w_expired) begin
                    w_state_nxt = S_HALT;
                    w_err_set   = 1'b1;
                end else if (!bus.bus_waitrequest) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_q   <= '0;
            r_data_q    <= '0;
            r_bus_error <= 1'b0;
        end else begin
            if ((r_state == S_FETCH) && w_accept) begin
                r_instr_q <= bus.bus_readdata;
            end
            if ((r_state == S_DATA) && w_accept && bus.data_read) begin
                r_data_q <= bus.bus_readdata;
            end
            if (w_err_set) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    // Strobes come straight from state so an async reset removes them at once.
    always_comb begin
        bus.bus_read       = 1'b0;
        bus.bus_write      = 1'b0;
        bus.bus_address    = '0;
        bus.bus_writedata  = '0;
        bus.bus_byteenable = BYTEEN_NONE;
        case (r_state)
            S_FETCH: begin
                bus.bus_read       = 1'b1;
                bus.bus_address    = word_align(bus.instr_address);
                bus.bus_byteenable = BYTEEN_FULL;
            end
            S_DATA: begin
                bus.bus_read       = bus.data_read;
                bus.bus_write      = bus.data_write;
                bus.bus_address    = word_align(bus.data_address);
                bus.bus_writedata  = bus.data_writedata;
                bus.bus_byteenable = BYTEEN_FULL;
            end
            default: begin
            end
        endcase
    end

    assign bus.cpu_clk_enable = (r_state == S_COMMIT);
    assign bus.instr_readdata = r_instr_q;
    assign bus.data_readdata  = r_data_q;
    assign bus.bus_error      = r_bus_error;

endmodule

`default_nettype wire

// File: tb/tb_harvard_bus_adapter.sv
// ============================================================================
//  Module   : tb_harvard_bus_adapter
//  Brief    : Randomised instruction stream against a per-instruction cycle
//             schedule derived from the adapter's bus protocol.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_harvard_bus_adapter;
    import mips_bus_pkg::*;

    localparam int TO = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int total = 0;
    int bad   = 0;

    logic        exp_ce  = 1'b0;
    logic        exp_rd  = 1'b0;
    logic        exp_wr  = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_addr  = '0;
    logic [31:0] exp_wdata = '0;
    logic [31:0] exp_iq    = '0;
    logic [31:0] exp_dq    = '0;

    int cyc       = 0;
    int ce_cnt    = 0;
    int a1000_cnt = 0;
    int wr_cnt    = 0;

    always #5 clk = ~clk;

    harvard_bus_adapter_if bif();

    harvard_bus_adapter #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.master)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: outputs against the schedule expectation.
    always @(negedge clk) begin
        chk1("cpu_clk_enable", bif.cpu_clk_enable, exp_ce);
        chk1("bus_read", bif.bus_read, exp_rd);
        chk1("bus_write", bif.bus_write, exp_wr);
        chk1("bus_error", bif.bus_error, exp_err);
        chk("bus_byteenable", {28'b0, bif.bus_byteenable}, (exp_rd || exp_wr) ? 32'hF : 32'h0);
        if (exp_rd || exp_wr) chk("bus_address", bif.bus_address, exp_addr);
        if (exp_wr) chk("bus_writedata", bif.bus_writedata, exp_wdata);
        chk("instr_readdata", bif.instr_readdata, exp_iq);
        chk("data_readdata", bif.data_readdata, exp_dq);
        if (bif.cpu_clk_enable) ce_cnt++;
        if ((bif.bus_read || bif.bus_write) && bif.bus_address == 32'h1000) a1000_cnt++;
        if (bif.bus_write && bif.bus_writedata == 32'h12345678 && bif.bus_byteenable == 4'hF) wr_cnt++;
    end

    task automatic step(input logic ce, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic wreq, input logic [31:0] rdata);
        exp_ce   = ce;
        exp_rd   = rd;
        exp_wr   = wr;
        exp_addr = addr;
        bif.bus_waitrequest = wreq;
        bif.bus_readdata    = rdata;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'($urandom), $urandom);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        exp_ce  = 1'b0;
        exp_rd  = 1'b0;
        exp_wr  = 1'b0;
        exp_err = 1'b0;
        exp_iq  = '0;
        exp_dq  = '0;
        repeat (2) idle_step();
        reset = 1'b1;
    endtask

    // One instruction: idle gaps, idle cycle, fetch (+waits), decode,
    // optional data phase (+waits), commit. Timeouts/conflicts end in halt.
    task automatic run_instr(input logic [31:0] ia, input logic [31:0] iw, input int fw,
                             input int kind, input logic [31:0] da, input logic [31:0] dd,
                             input int dw, input int gaps, input bit drop,
                             output int ncyc, output bit halted);
        logic rd;
        logic wr;
        halted = 1'b0;
        rd = (kind == 1) || (kind == 3);
        wr = (kind == 2) || (kind == 3);
        bif.cpu_active = 1'b0;
        for (int g = 0; g < gaps; g++) idle_step();
        bif.instr_address  = ia;
        bif.data_address   = da;
        bif.data_read      = rd;
        bif.data_write     = wr;
        bif.data_writedata = dd;
        exp_wdata          = dd;
        bif.cpu_active     = 1'b1;
        ncyc = cyc;
        idle_step();
        if (drop) bif.cpu_active = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            if (i == TO) begin
                halted = 1'b1;
                break;
            end
            step(1'b0, 1'b1, 1'b0, {ia[31:2], 2'b00}, i < fw, (i < fw) ? $urandom : iw);
        end
        if (!halted) begin
            exp_iq = iw;
            idle_step();
            if (rd && wr) halted = 1'b1;
        end
        if (!halted && (rd || wr)) begin
            for (int j = 0; j <= dw; j++) begin
                if (j == TO) begin
                    halted = 1'b1;
                    break;
                end
                step(1'b0, rd, wr, {da[31:2], 2'b00}, j < dw, (j < dw) ? $urandom : dd);
            end
            if (!halted && rd) exp_dq = dd;
        end
        if (!halted) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, $urandom);
        ncyc = cyc - ncyc;
        if (halted) begin
            exp_err = 1'b1;
            bif.cpu_active = 1'b1;
            repeat (3) idle_step();
        end
    endtask

    initial begin
        int n;
        bit h;
        int c0;
        int a0;
        int w0;
        bif.cpu_active      = 1'b0;
        bif.instr_address   = '0;
        bif.data_address    = '0;
        bif.data_read       = 1'b0;
        bif.data_write      = 1'b0;
        bif.data_writedata  = '0;
        bif.bus_waitrequest = 1'b0;
        bif.bus_readdata    = '0;
        do_reset();

        // Reset asserted in the middle of a store's data phase.
        bif.instr_address  = 32'h100;
        bif.data_address   = 32'h44;
        bif.data_read      = 1'b0;
        bif.data_write     = 1'b1;
        bif.data_writedata = 32'hCAFEF00D;
        exp_wdata          = 32'hCAFEF00D;
        bif.cpu_active     = 1'b1;
        idle_step();
        step(1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'hAC0A0044);
        exp_iq = 32'hAC0A0044;
        idle_step();
        exp_wr   = 1'b1;
        exp_addr = 32'h44;
        bif.bus_waitrequest = 1'b1;
        #2;
        chk1("pre_reset_write", bif.bus_write, 1'b1);
        exp_wr = 1'b0;
        exp_iq = '0;
        reset  = 1'b0;
        #1;
        chk1("reset_drops_write", bif.bus_write, 1'b0);
        chk("reset_instr_q", bif.instr_readdata, 32'h0);
        chk1("reset_error", bif.bus_error, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // addiu, no wait states
        c0 = ce_cnt;
        run_instr(32'h400, 32'h24020005, 0, 0, 32'h0, 32'h0, 0, 0, 1'b0, n, h);
        chk("addiu_cycles", n, 32'd4);
        chk("addiu_pulses", ce_cnt - c0, 32'd1);
        chk("addiu_instr", bif.instr_readdata, 32'h24020005);

        // lw from an unaligned address with two wait states
        c0 = ce_cnt;
        a0 = a1000_cnt;
        run_instr(32'h404, 32'h8C221003, 0, 1, 32'h1003, 32'hDEADBEEF, 2, 1, 1'b0, n, h);
        chk("lw_cycles", n, 32'd7);
        chk("lw_addr_cycles", a1000_cnt - a0, 32'd3);
        chk("lw_pulses", ce_cnt - c0, 32'd1);
        chk("lw_data", bif.data_readdata, 32'hDEADBEEF);

        // sw, no wait states
        w0 = wr_cnt;
        run_instr(32'h408, 32'hAC220020, 0, 2, 32'h20, 32'h12345678, 0, 0, 1'b0, n, h);
        chk("sw_cycles", n, 32'd5);
        chk("sw_write_cycles", wr_cnt - w0, 32'd1);

        // cpu_active low for a while, and dropped mid-access
        run_instr(32'h40C, 32'h00000000, 1, 0, 32'h0, 32'h0, 0, 5, 1'b1, n, h);
        chk("drop_cycles", n, 32'd5);

        // fetch timeout
        c0 = ce_cnt;
        run_instr(32'h410, 32'h12345678, 6, 0, 32'h0, 32'h0, 0, 0, 1'b0, n, h);
        chk1("timeout_error", bif.bus_error, 1'b1);
        chk1("timeout_read_low", bif.bus_read, 1'b0);
        chk("timeout_no_pulse", ce_cnt - c0, 32'd0);
        do_reset();
        chk1("reset_clears_error", bif.bus_error, 1'b0);

        // simultaneous read and write request
        run_instr(32'h414, 32'h11111111, 0, 3, 32'h80, 32'h5, 0, 0, 1'b0, n, h);
        chk1("rw_conflict_error", bif.bus_error, 1'b1);
        do_reset();

        for (int k = 0; k < 60; k++) begin
            int kind;
            int fw;
            int dw;
            int r;
            r    = $urandom_range(0, 19);
            kind = (r == 0) ? 3 : (r < 9) ? 0 : (r < 15) ? 1 : 2;
            fw   = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            dw   = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            run_instr($urandom, $urandom, fw, kind, $urandom, $urandom, dw,
                      $urandom_range(0, 2), $urandom_range(0, 3) == 0, n, h);
            if (h) begin
                do_reset();
            end else begin
                chk("latency", n, 32'(4 + fw + ((kind == 0) ? 0 : 1 + dw)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
